// File: rtl/brainfuck_uart_pkg.sv
// Shared definitions for the interpreter's UART transmit path.
package brainfuck_uart_pkg;

    // Serialiser states; encodings are fixed so debug probes stay readable.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // 8N1: one start bit, eight data bits, one stop bit.
    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = UART_FRAME_BITS - 2;

endpackage

// File: rtl/brainfuck_byte_fifo.sv
// Small synchronous byte FIFO with first-word-fall-through read data.
// Writes while full and reads while empty are ignored.
module brainfuck_byte_fifo #(
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [FIFO_ADDR_WIDTH:0] count
);

    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic                       do_wr;
    logic                       do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (FIFO_ADDR_WIDTH + 1)'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // Storage array: written on accepted writes.
    // NOTE: the data array has no reset; occupancy is tracked by count, so stale contents are never observed and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/brainfuck_uart_tx.sv
// Buffers interpreter output bytes and serialises them as 8N1 UART, LSB first.
// output_busy is FIFO-full backpressure; overflow is sticky until reset.
module brainfuck_uart_tx
    import brainfuck_uart_pkg::*;
#(
    parameter int CLK_DIV         = 434,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic [7:0] output_data,
    input  logic       output_write,
    output logic       output_busy,
    output logic       tx,
    output logic       idle,
    output logic       overflow
);

    localparam int                BAUD_W      = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

    tx_state_t                state;
    logic [BAUD_W-1:0]        baud_cnt;
    logic [2:0]               bit_idx;
    logic [7:0]               shift;

    logic                     fifo_wr;
    logic                     fifo_pop;
    logic [7:0]               fifo_rd_data;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [FIFO_ADDR_WIDTH:0] fifo_count;

    assign output_busy = fifo_full;
    assign fifo_wr     = output_write && !output_busy;
    // A new byte is taken from the FIFO when idle, or at the end of a stop bit
    // so consecutive frames follow with no gap.
    assign fifo_pop    = !fifo_empty &&
                         ((state == TX_IDLE) || (state == TX_STOP && baud_cnt == '0));
    assign idle        = (fifo_count == '0) && (state == TX_IDLE);

    brainfuck_byte_fifo #(
        .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .wr_data (output_data),
        .wr_en   (fifo_wr),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Sticky flag: a write strobe while the FIFO is full loses that byte.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            overflow <= 1'b0;
        end else if (output_write && output_busy) begin
            overflow <= 1'b1;
        end
    end

    // Serialiser: tx is registered and set one cycle ahead for each bit.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (fifo_pop) begin
                        shift    <= fifo_rd_data;
                        baud_cnt <= BAUD_RELOAD;
                        tx       <= 1'b0;
                        state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        state    <= TX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= BAUD_RELOAD;
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                TX_STOP: begin
                    if (baud_cnt == '0) begin
                        if (fifo_pop) begin
                            shift    <= fifo_rd_data;
                            baud_cnt <= BAUD_RELOAD;
                            tx       <= 1'b0;
                            state    <= TX_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= TX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brainfuck_uart_tx.sv
// Scoreboard bench: stimulus pushes expected bytes, a line monitor decodes
// frames on the falling clock edge and compares every bit over its full width.
module tb_brainfuck_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int AW      = 2;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] output_data;
    logic       output_write;
    logic       output_busy;
    logic       tx;
    logic       idle;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] sb[$];     // expected bytes, in line order
    int         starts[$]; // cycle stamp of each observed start bit

    // monitor state
    logic       in_frame = 1'b0;
    logic [9:0] exp_frame;
    logic [3:0] samp;
    int         bit_i;
    int         sub;
    int         frame_no = 0;

    int w;
    int wcyc;

    brainfuck_uart_tx #(
        .CLK_DIV         (CLK_DIV),
        .FIFO_ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .output_data  (output_data),
        .output_write (output_write),
        .output_busy  (output_busy),
        .tx           (tx),
        .idle         (idle),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line monitor: start detection, then four samples per bit, each compared.
    always @(negedge clk) begin
        if (rst_i === 1'b1) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                check("frame_expected", {31'd0, sb.size() != 0}, 32'd1);
                exp_frame = {1'b1, (sb.size() != 0) ? sb.pop_front() : 8'h00, 1'b0};
                starts.push_back(cyc);
                samp      = 4'b0000;
                bit_i     = 0;
                sub       = 1;
                in_frame  = 1'b1;
            end
        end else begin
            samp[sub] = tx;
            sub++;
            if (sub == CLK_DIV) begin
                check($sformatf("frame%0d_bit%0d", frame_no, bit_i),
                      {28'd0, samp}, {28'd0, {4{exp_frame[bit_i]}}});
                bit_i++;
                sub = 0;
                if (bit_i == 10) begin
                    in_frame = 1'b0;
                    frame_no++;
                end
            end
        end
    end

    task automatic do_write(input logic [7:0] d, input bit accept);
        output_data  = d;
        output_write = 1'b1;
        if (accept) sb.push_back(d);
        @(posedge clk);
        #1;
        wcyc         = cyc;
        output_write = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain(input int max_cycles, input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            #1;
            if (idle && !in_frame && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with no clock edges yet.
        rst_i        = 1'b1;
        output_write = 1'b0;
        output_data  = 8'h00;
        #1;
        check("rst_tx",       {31'd0, tx},          32'd1);
        check("rst_busy",     {31'd0, output_busy}, 32'd0);
        check("rst_idle",     {31'd0, idle},        32'd1);
        check("rst_overflow", {31'd0, overflow},    32'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        // Single byte 0x55: start right after the pop edge, idle one cycle after stop.
        starts.delete();
        do_write(8'h55, 1'b1);
        w = wcyc;
        wait_cyc(w + 40);
        check("t1_idle_in_stop", {31'd0, idle}, 32'd0);
        @(negedge clk);
        check("t1_idle_after", {31'd0, idle}, 32'd1);
        drain(100, "t1_drain");
        check("t1_nframes", starts.size(), 32'd1);
        if (starts.size() >= 1) check("t1_start_cyc", starts[0], w + 1);

        // 0x00 then 0xFF on consecutive edges: back-to-back frames.
        starts.delete();
        do_write(8'h00, 1'b1);
        w = wcyc;
        do_write(8'hFF, 1'b1);
        drain(200, "t2_drain");
        check("t2_nframes", starts.size(), 32'd2);
        if (starts.size() >= 2) begin
            check("t2_start_cyc", starts[0], w + 1);
            check("t2_gap", starts[1] - starts[0], 32'd40);
        end

        // Fill to backpressure, overflow, busy release, write on a pop edge.
        starts.delete();
        check("t3_ovf_before", {31'd0, overflow}, 32'd0);
        do_write(8'h01, 1'b1);
        w = wcyc;
        do_write(8'h02, 1'b1);
        do_write(8'h03, 1'b1);
        do_write(8'h04, 1'b1);
        @(negedge clk);
        check("t3_busy_at3", {31'd0, output_busy}, 32'd0);
        do_write(8'h05, 1'b1);
        @(negedge clk);
        check("t3_busy_at4", {31'd0, output_busy}, 32'd1);
        check("t3_ovf_at4",  {31'd0, overflow},    32'd0);
        do_write(8'h06, 1'b0);
        @(negedge clk);
        check("t3_ovf_set",   {31'd0, overflow},    32'd1);
        check("t3_busy_held", {31'd0, output_busy}, 32'd1);
        wait_cyc(w + 40);
        check("t3_busy_pre_pop2", {31'd0, output_busy}, 32'd1);
        @(negedge clk);
        check("t3_busy_released", {31'd0, output_busy}, 32'd0);
        check("t3_count_3",       {29'd0, dut.u_fifo.count}, 32'd3);
        wait_cyc(w + 80);
        do_write(8'hA3, 1'b1);
        @(negedge clk);
        check("t3_simul_busy",  {31'd0, output_busy},      32'd0);
        check("t3_simul_count", {29'd0, dut.u_fifo.count}, 32'd3);
        drain(400, "t3_drain");
        check("t3_nframes", starts.size(), 32'd6);
        if (starts.size() >= 6) begin
            check("t3_start_cyc", starts[0], w + 1);
            for (int i = 1; i < 6; i++)
                check($sformatf("t3_gap%0d", i), starts[i] - starts[i-1], 32'd40);
        end
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset during the start bit returns tx high without a clock edge.
        do_write(8'h0F, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (tx === 1'b0) break;
            @(negedge clk);
        end
        #1;
        check("t4_tx_low_pre", {31'd0, tx}, 32'd0);
        rst_i = 1'b1;
        #1;
        check("t4_tx_rst",       {31'd0, tx},          32'd1);
        check("t4_idle_rst",     {31'd0, idle},        32'd1);
        check("t4_busy_rst",     {31'd0, output_busy}, 32'd0);
        check("t4_overflow_rst", {31'd0, overflow},    32'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        sb.delete();
        starts.delete();
        @(negedge clk);
        do_write(8'h3C, 1'b1);
        drain(100, "t4_drain");
        check("t4_nframes", starts.size(), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/brainfuck_uart_tx.md
Name: brainfuck_uart_tx

Overview:
- Downstream consumer of the interpreter's byte output port (output_data / output_write / output_busy).
- Buffers bytes in a small synchronous FIFO and serialises them onto a UART line as 8N1, LSB first.
- Drives output_busy back to the interpreter as FIFO-full backpressure.
- Sits between the brainfuck top level and the board TX pin.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
- FIFO_ADDR_WIDTH, 4, FIFO depth = 2**FIFO_ADDR_WIDTH bytes.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_i  input  1  asynchronous, active-high reset. Top level inverts as needed when wiring to the existing active-low rst_i.
- output_data  input  8  byte from interpreter.
- output_write  input  1  one-cycle write strobe; valid only when output_busy is low.
- output_busy  output  1  high when FIFO holds DEPTH bytes.
- tx  output  1  UART serial line, idle high.
- idle  output  1  high when FIFO is empty and the serialiser is in TX_IDLE.
- overflow  output  1  sticky; set when output_write is sampled while output_busy is high.

Behaviour:
- Reset (async, immediate, no clock needed):
  - tx=1, output_busy=0, idle=1, overflow=0.
  - FIFO count=0, pointers=0, state TX_IDLE, baud counter=0.
- FIFO:
  - Count register is FIFO_ADDR_WIDTH+1 bits wide; pointers wrap modulo DEPTH.
  - output_busy = (count == DEPTH), decoded from registered count.
  - Write is accepted iff output_write && !output_busy at the sampling edge.
  - A write sampled while busy is dropped and sets overflow. This holds even if a pop occurs on the same edge.
  - Simultaneous accepted write and pop: count is unchanged, both pointers advance.
- Serialiser FSM states:
  - TX_IDLE: tx=1. If FIFO is non-empty, pop the head into the shift register, load the baud counter with CLK_DIV-1, and go to TX_START.
  - TX_START: tx=0 for CLK_DIV cycles. On baud counter==0, reload it, set bit index=0, go to TX_DATA.
  - TX_DATA: tx=shift[0]. On baud counter==0, shift right and increment the index; after index 7 completes, go to TX_STOP.
  - TX_STOP: tx=1 for CLK_DIV cycles. At end: if FIFO is non-empty, pop and go directly to TX_START (no idle gap); otherwise go to TX_IDLE.
- Timing:
  - Every bit lasts exactly CLK_DIV cycles; a frame lasts exactly 10*CLK_DIV cycles.
  - Back-to-back frames have zero gap.
  - Latency: a write accepted at edge N causes the TX_IDLE pop at edge N+1; tx falls after edge N+1.
- tx is a registered output (no glitches).
- Baud counter width is $clog2(CLK_DIV); it counts down and reloads at 0.
- idle is registered/decoded from registered state only.
- Reset mid-frame truncates the frame; tx returns high asynchronously. This is acceptable and is not flagged.
- overflow clears only on reset.

Decomposition:
- Shared package (brainfuck_uart_pkg) holds:
  - state encoding TX_IDLE=2'd0, TX_START=2'd1, TX_DATA=2'd2, TX_STOP=2'd3;
  - UART_FRAME_BITS=10.
- One sub-module, brainfuck_byte_fifo (parameter FIFO_ADDR_WIDTH):
  - ports clk, rst_i, wr_data, wr_en, rd_en, rd_data (first-word-fall-through), empty, full, count.
  - Reused later for an input-side receiver.

Test Plan (CLK_DIV=4, FIFO_ADDR_WIDTH=2):
- Reset, with no clock edges:
  - Assert rst_i -> tx=1, output_busy=0, idle=1, overflow=0.
  - Pulse rst_i mid-frame -> tx=1 before the next clock edge.
- Single byte:
  - Write 0x55 at edge 0 -> tx low for cycles 2-5.
  - Then tx = 1,0,1,0,1,0,1,0 for 4 cycles each.
  - Then tx high for 4 cycles; idle=1 at cycle 42.
- Data integrity:
  - Write 0x00 then 0xFF on consecutive edges -> two frames with zero gap (80 cycles).
  - Data bits read all-0, then all-1.
- Fill/backpressure:
  - Write 0x01..0x06 on 6 consecutive edges -> output_busy rises after edge 4.
  - 0x06 is dropped and overflow=1.
  - Line carries 0x01..0x05 in 200 contiguous cycles.
- Busy release:
  - After the fill, output_busy falls the edge after the second pop.
  - A new write of 0xA3 is accepted and appears as the 6th frame.
- Simultaneous write+pop at count=3:
  - count stays 3, output_busy stays 0, no byte lost or duplicated on the line.
